// File: rtl/frame_out_pkg.sv
// frame_out_pkg: shared types, default geometry and CRC helpers for the frame output streamer.
//   fetch_state_e      - fetch FSM states
//   PIX_BITS           - default pixel width (3 bytes)
//   BLOCK_BITS         - default SRAM block width (64 pixels)
//   BLOCKS_PER_FRAME   - default blocks per frame (65536 / 64)
//   CRC16_POLY/INIT    - CRC-16-CCITT constants, crc16_upd_byte() byte-wise update (MSB first)
package frame_out_pkg;

   typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, DONE} fetch_state_e;

   localparam int unsigned PIX_BITS         = 24;
   localparam int unsigned BLOCK_BITS       = PIX_BITS * 64;
   localparam int unsigned BLOCKS_PER_FRAME = 65536 / 64;

   localparam logic [15:0] CRC16_POLY = 16'h1021;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

   function automatic logic [15:0] crc16_upd_byte(input logic [15:0] crc, input logic [7:0] data);
      logic [15:0] c;
      c = crc;
      for (int i = 7; i >= 0; i--) begin
         if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
         else                 c = {c[14:0], 1'b0};
      end
      return c;
   endfunction

endpackage

// File: rtl/block_pingpong.sv
// block_pingpong: two-entry block register file feeding a pixel stream.
//   clk, n_rst    - clock, asynchronous active-low reset
//   i_wr_en       - capture i_wr_data into the write-side entry
//   i_wr_data     - one SRAM block (PIX_PER_BLK pixels, pixel 0 in the LSBs)
//   i_pop         - sink accepts the current pixel (ignored when nothing is buffered)
//   o_free        - at least one entry is free
//   o_valid       - at least one entry is filled
//   o_pix_data    - current pixel of the read-side entry
module block_pingpong
   import frame_out_pkg::*;
#(
   parameter int unsigned PIX_W       = PIX_BITS,
   parameter int unsigned PIX_PER_BLK = BLOCK_BITS / PIX_BITS
) (
   input  logic                         clk,
   input  logic                         n_rst,
   input  logic                         i_wr_en,
   input  logic [PIX_W*PIX_PER_BLK-1:0] i_wr_data,
   input  logic                         i_pop,
   output logic                         o_free,
   output logic                         o_valid,
   output logic [PIX_W-1:0]             o_pix_data
);

   localparam int unsigned LP_BLK_W = PIX_W * PIX_PER_BLK;
   localparam int unsigned LP_K_W   = (PIX_PER_BLK > 1) ? $clog2(PIX_PER_BLK) : 1;

   logic [LP_BLK_W-1:0] r_entry [2];
   logic                r_wr_ptr;
   logic                r_rd_ptr;
   logic [1:0]          r_fill;
   logic [1:0]          w_fill_d;
   logic [LP_K_W-1:0]   r_k;
   logic                w_pop;
   logic                w_release;

   assign o_valid   = (r_fill != 2'd0);
   assign o_free    = (r_fill != 2'd2);
   assign w_pop     = i_pop & o_valid;
   assign w_release = w_pop & (r_k == LP_K_W'(PIX_PER_BLK - 1));

   assign o_pix_data = r_entry[r_rd_ptr][r_k*PIX_W +: PIX_W];

   // Capture and release in the same cycle leave the fill count unchanged.
   always_comb begin
      w_fill_d = r_fill;
      unique case ({i_wr_en, w_release})
         2'b10:   w_fill_d = r_fill + 2'd1;
         2'b01:   w_fill_d = r_fill - 2'd1;
         default: w_fill_d = r_fill;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_entry[0] <= '0;
         r_entry[1] <= '0;
         r_wr_ptr   <= 1'b0;
         r_rd_ptr   <= 1'b0;
         r_fill     <= 2'd0;
         r_k        <= '0;
      end else begin
         if (i_wr_en) begin
            r_entry[r_wr_ptr] <= i_wr_data;
            r_wr_ptr          <= ~r_wr_ptr;
         end
         if (w_release) r_rd_ptr <= ~r_rd_ptr;
         if (w_pop)     r_k      <= w_release ? '0 : r_k + LP_K_W'(1);
         r_fill <= w_fill_d;
      end
   end

endmodule

// File: rtl/frame_out_streamer.sv
// frame_out_streamer: fetches the blended output buffer from SRAM in blocks and serialises it
// into a valid/ready pixel stream. Block fetches (2 cycles) overlap pixel streaming through a
// ping-pong block buffer, so a permanently ready sink sees one pixel per clock.
//   clk, n_rst         - clock, asynchronous active-low reset (aborts a frame, no frame_done)
//   i_start            - one-cycle pulse, starts a frame when idle
//   o_busy             - start accepted .. frame_done cycle inclusive
//   o_frame_done       - one-cycle pulse after the last pixel handshake
//   o_read_enable      - SRAM read request; i_read_data captured at the end of the next cycle
//   o_address          - SRAM pixel address, 0 while o_read_enable is low
//   i_read_data        - SRAM block data, pixel 0 in the LSBs
//   o_pix_valid/i_pix_ready/o_pix_data/o_pix_last - pixel stream
// Optional: FRAME_OUT_CRC_EN adds o_frame_crc, a CRC-16-CCITT over every accepted pixel
// (bytes MSB first), valid from frame_done until the next start.
module frame_out_streamer
   import frame_out_pkg::*;
#(
   parameter int unsigned ADDR_SIZE_BITS  = 24,
   parameter int unsigned WORD_SIZE_BYTES = PIX_BITS / 8,
   parameter int unsigned DATA_SIZE_WORDS = BLOCK_BITS / PIX_BITS,
   parameter int unsigned BASE_ADDR       = 143360,
   parameter int unsigned FRAME_PIXELS    = BLOCKS_PER_FRAME * (BLOCK_BITS / PIX_BITS)
) (
   input  logic                                       clk,
   input  logic                                       n_rst,
   input  logic                                       i_start,
   output logic                                       o_busy,
   output logic                                       o_frame_done,
   output logic                                       o_read_enable,
   output logic [ADDR_SIZE_BITS-1:0]                  o_address,
   input  logic [WORD_SIZE_BYTES*DATA_SIZE_WORDS*8-1:0] i_read_data,
   output logic                                       o_pix_valid,
   input  logic                                       i_pix_ready,
   output logic [WORD_SIZE_BYTES*8-1:0]               o_pix_data,
   output logic                                       o_pix_last
`ifdef FRAME_OUT_CRC_EN
   ,
   output logic [15:0]                                o_frame_crc
`endif
);

   localparam int unsigned LP_PIX_W  = WORD_SIZE_BYTES * 8;
   localparam int unsigned LP_BLOCKS = FRAME_PIXELS / DATA_SIZE_WORDS;
   localparam int unsigned LP_FB_W   = $clog2(LP_BLOCKS) + 1;
   localparam int unsigned LP_PC_W   = $clog2(FRAME_PIXELS) + 1;

   fetch_state_e          r_state, w_state_d;
   logic [LP_FB_W-1:0]    r_fb, w_fb_d;
   logic [LP_PC_W-1:0]    r_pix, w_pix_d;
   logic                  w_free;
   logic                  w_valid;
   logic                  w_hs;
   logic                  w_wr_en;
   logic                  w_rd_en;
   logic                  w_done;
   logic                  w_pix_last;
   logic [LP_PIX_W-1:0]   w_pix_data;

   block_pingpong #(
      .PIX_W       (LP_PIX_W),
      .PIX_PER_BLK (DATA_SIZE_WORDS)
   ) u_pingpong (
      .clk        (clk),
      .n_rst      (n_rst),
      .i_wr_en    (w_wr_en),
      .i_wr_data  (i_read_data),
      .i_pop      (i_pix_ready),
      .o_free     (w_free),
      .o_valid    (w_valid),
      .o_pix_data (w_pix_data)
   );

   assign w_hs       = w_valid & i_pix_ready;
   assign w_pix_last = w_valid & (r_pix == LP_PC_W'(FRAME_PIXELS - 1));

   always_comb begin
      w_state_d = r_state;
      w_fb_d    = r_fb;
      w_rd_en   = 1'b0;
      w_wr_en   = 1'b0;
      w_done    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (i_start) begin
               w_state_d = REQ;
               w_fb_d    = '0;
            end
         end
         REQ: begin
            if (w_free) begin
               w_rd_en   = 1'b1;
               w_state_d = WAIT;
            end
         end
         WAIT: begin
            w_wr_en   = 1'b1;
            w_fb_d    = r_fb + LP_FB_W'(1);
            w_state_d = (w_fb_d == LP_FB_W'(LP_BLOCKS)) ? DRAIN : REQ;
         end
         DRAIN: begin
            // The last handshake also releases the last entry, so the buffer is empty.
            if (w_hs && w_pix_last) w_state_d = DONE;
         end
         DONE: begin
            w_done    = 1'b1;
            w_state_d = IDLE;
         end
         default: w_state_d = IDLE;
      endcase
   end

   always_comb begin
      w_pix_d = r_pix;
      if (r_state == IDLE && i_start) w_pix_d = '0;
      else if (w_hs)                  w_pix_d = r_pix + LP_PC_W'(1);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         r_state <= IDLE;
         r_fb    <= '0;
         r_pix   <= '0;
      end else begin
         r_state <= w_state_d;
         r_fb    <= w_fb_d;
         r_pix   <= w_pix_d;
      end
   end

   assign o_busy        = (r_state != IDLE);
   assign o_frame_done  = w_done;
   assign o_read_enable = w_rd_en;
   assign o_address     = w_rd_en ? (ADDR_SIZE_BITS'(BASE_ADDR) +
                                     ADDR_SIZE_BITS'(r_fb) * ADDR_SIZE_BITS'(DATA_SIZE_WORDS))
                                  : '0;
   assign o_pix_valid   = w_valid;
   assign o_pix_data    = w_pix_data;
   assign o_pix_last    = w_pix_last;

`ifdef FRAME_OUT_CRC_EN
   logic [15:0] r_crc, w_crc_d;

   always_comb begin
      w_crc_d = r_crc;
      if (r_state == IDLE && i_start) begin
         w_crc_d = CRC16_INIT;
      end else if (w_hs) begin
         for (int i = int'(WORD_SIZE_BYTES) - 1; i >= 0; i--) begin
            w_crc_d = crc16_upd_byte(w_crc_d, w_pix_data[i*8 +: 8]);
         end
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) r_crc <= '0;
      else        r_crc <= w_crc_d;
   end

   assign o_frame_crc = r_crc;
`endif

endmodule

// File: tb/tb_frame_out_streamer.sv
`timescale 1ns/1ps
module tb_frame_out_streamer;

   localparam int unsigned BASE = 143360;
   localparam int unsigned BLKW = 1536;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Full-size DUT (65536 pixels)
   logic            f_n_rst, f_start, f_busy, f_done, f_re, f_valid, f_ready, f_last;
   logic [23:0]     f_addr, f_data;
   logic [BLKW-1:0] f_rdata;
   // Small DUT (128 pixels)
   logic            s_n_rst, s_start, s_busy, s_done, s_re, s_valid, s_ready, s_last;
   logic [23:0]     s_addr, s_data;
   logic [BLKW-1:0] s_rdata;
`ifdef FRAME_OUT_CRC_EN
   logic [15:0]     f_crc, s_crc, c_crc;
   // CRC DUT (64 pixels, all-zero data)
   logic            c_n_rst, c_start, c_busy, c_done, c_re, c_valid, c_ready, c_last;
   logic [23:0]     c_addr, c_data;
   logic [BLKW-1:0] c_rdata;
`endif

   frame_out_streamer u_dut_full (
      .clk(clk), .n_rst(f_n_rst), .i_start(f_start), .o_busy(f_busy), .o_frame_done(f_done),
      .o_read_enable(f_re), .o_address(f_addr), .i_read_data(f_rdata), .o_pix_valid(f_valid),
      .i_pix_ready(f_ready), .o_pix_data(f_data), .o_pix_last(f_last)
`ifdef FRAME_OUT_CRC_EN
      , .o_frame_crc(f_crc)
`endif
   );

   frame_out_streamer #(.FRAME_PIXELS(128)) u_dut_small (
      .clk(clk), .n_rst(s_n_rst), .i_start(s_start), .o_busy(s_busy), .o_frame_done(s_done),
      .o_read_enable(s_re), .o_address(s_addr), .i_read_data(s_rdata), .o_pix_valid(s_valid),
      .i_pix_ready(s_ready), .o_pix_data(s_data), .o_pix_last(s_last)
`ifdef FRAME_OUT_CRC_EN
      , .o_frame_crc(s_crc)
`endif
   );

`ifdef FRAME_OUT_CRC_EN
   frame_out_streamer #(.FRAME_PIXELS(64)) u_dut_crc (
      .clk(clk), .n_rst(c_n_rst), .i_start(c_start), .o_busy(c_busy), .o_frame_done(c_done),
      .o_read_enable(c_re), .o_address(c_addr), .i_read_data(c_rdata), .o_pix_valid(c_valid),
      .i_pix_ready(c_ready), .o_pix_data(c_data), .o_pix_last(c_last), .o_frame_crc(c_crc)
   );
`endif

   // Block b, pixel k = {b[7:0], k[7:0], 8'hA5}
   function automatic logic [BLKW-1:0] mk_block(input int b);
      logic [BLKW-1:0] blk;
      logic [7:0]      bb;
      bb = 8'(b);
      for (int k = 0; k < 64; k++) blk[k*24 +: 24] = {bb, 8'(k), 8'hA5};
      return blk;
   endfunction

   function automatic logic [23:0] exp_pix(input int idx);
      logic [7:0] bb;
      logic [7:0] kk;
      bb = 8'(idx / 64);
      kk = 8'(idx % 64);
      return {bb, kk, 8'hA5};
   endfunction

   // Bit-serial CRC-16-CCITT reference over nbytes zero bytes
   function automatic logic [15:0] ref_crc_zero(input int nbytes);
      logic [15:0] c;
      logic [7:0]  d;
      logic        fb;
      c = 16'hFFFF;
      d = 8'h00;
      for (int n = 0; n < nbytes; n++) begin
         for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
         end
      end
      return c;
   endfunction

   // SRAM models: data presented the cycle after the request
   always @(posedge clk) begin
      if (f_re) f_rdata <= mk_block((int'(f_addr) - int'(BASE)) / 64);
      if (s_re) s_rdata <= mk_block((int'(s_addr) - int'(BASE)) / 64);
   end
`ifdef FRAME_OUT_CRC_EN
   assign c_rdata = '0;
`endif

   task automatic test_reset();
      f_n_rst = 1'b0;
      s_n_rst = 1'b0;
`ifdef FRAME_OUT_CRC_EN
      c_n_rst = 1'b0;
`endif
      repeat (2) @(negedge clk);
      n_checks++;
      if ({f_busy, f_done, f_re, f_valid, f_last} !== 5'b0) begin
         n_errors++;
         $display("FAIL reset_full_ctrl: got %b want 00000", {f_busy, f_done, f_re, f_valid, f_last});
      end
      n_checks++;
      if (f_addr !== 24'd0) begin
         n_errors++; $display("FAIL reset_full_addr: got %0d want 0", f_addr);
      end
      n_checks++;
      if (f_data !== 24'd0) begin
         n_errors++; $display("FAIL reset_full_data: got %h want 000000", f_data);
      end
      n_checks++;
      if ({s_busy, s_done, s_re, s_valid, s_last} !== 5'b0) begin
         n_errors++;
         $display("FAIL reset_small_ctrl: got %b want 00000", {s_busy, s_done, s_re, s_valid, s_last});
      end
      f_n_rst = 1'b1;
      s_n_rst = 1'b1;
`ifdef FRAME_OUT_CRC_EN
      c_n_rst = 1'b1;
`endif
      repeat (2) @(negedge clk);
      n_checks++;
      if (f_busy !== 1'b0 || f_re !== 1'b0) begin
         n_errors++; $display("FAIL idle_no_start: busy %b re %b want 0 0", f_busy, f_re);
      end
   endtask

   task automatic test_ready_low();
      int reads = 0;
      int held_bad = 0;
      int valid_cnt = 0;
      f_ready = 1'b0;
      f_start = 1'b1;
      @(negedge clk);
      f_start = 1'b0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         if (f_re) reads++;
         if (f_valid) begin
            valid_cnt++;
            if (f_data !== 24'h0000A5) held_bad++;
         end
         @(negedge clk);
      end
      n_checks++;
      if (reads !== 2) begin
         n_errors++; $display("FAIL stall_reads: got %0d want 2", reads);
      end
      n_checks++;
      if (held_bad !== 0) begin
         n_errors++; $display("FAIL stall_pixel0_held: got %0d bad cycles want 0", held_bad);
      end
      n_checks++;
      if (valid_cnt !== 18) begin
         n_errors++; $display("FAIL stall_valid_cycles: got %0d want 18", valid_cnt);
      end
      n_checks++;
      if ({f_valid, f_re, f_busy} !== 3'b101) begin
         n_errors++; $display("FAIL stall_end_state: got %b want 101", {f_valid, f_re, f_busy});
      end
      // Abort the stalled frame
      f_n_rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({f_busy, f_valid, f_done} !== 3'b000) begin
         n_errors++; $display("FAIL abort_outputs: got %b want 000", {f_busy, f_valid, f_done});
      end
      f_n_rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_full_frame();
      int reads = 0, addr_bad = 0, hs = 0, pix_bad = 0, gaps = 0, lasts = 0;
      int last_hs = -1, last_cyc = -1, done_cnt = 0, done_cyc = -1, first_valid = -1;
      int busy_bad = 0;
      f_ready = 1'b1;
      f_start = 1'b1;
      @(negedge clk);
      f_start = 1'b0;
      for (int cyc = 0; cyc < 70000 && done_cnt == 0; cyc++) begin
         if (f_re) begin
            if (f_addr !== 24'(BASE + reads * 64)) addr_bad++;
            reads++;
         end
         if (f_valid && first_valid < 0) first_valid = cyc;
         if (first_valid >= 0 && !f_valid && hs < 65536) gaps++;
         if (!f_busy) busy_bad++;
         if (f_last) begin
            lasts++; last_hs = hs; last_cyc = cyc;
         end
         if (f_valid) begin
            if (f_data !== exp_pix(hs)) pix_bad++;
            hs++;
         end
         if (f_done) begin
            done_cnt++; done_cyc = cyc;
         end
         @(negedge clk);
      end
      n_checks++;
      if (reads !== 1024) begin
         n_errors++; $display("FAIL full_reads: got %0d want 1024", reads);
      end
      n_checks++;
      if (addr_bad !== 0) begin
         n_errors++; $display("FAIL full_addr_seq: got %0d bad addresses want 0", addr_bad);
      end
      n_checks++;
      if (hs !== 65536) begin
         n_errors++; $display("FAIL full_handshakes: got %0d want 65536", hs);
      end
      n_checks++;
      if (pix_bad !== 0) begin
         n_errors++; $display("FAIL full_pixel_order: got %0d bad pixels want 0", pix_bad);
      end
      n_checks++;
      if (first_valid !== 2) begin
         n_errors++; $display("FAIL full_first_valid: got cycle %0d want 2", first_valid);
      end
      n_checks++;
      if (gaps !== 0) begin
         n_errors++; $display("FAIL full_valid_gaps: got %0d want 0", gaps);
      end
      n_checks++;
      if (lasts !== 1 || last_hs !== 65535) begin
         n_errors++; $display("FAIL full_pix_last: got %0d at pixel %0d want 1 at 65535", lasts, last_hs);
      end
      n_checks++;
      if (done_cnt !== 1 || done_cyc !== last_cyc + 1) begin
         n_errors++;
         $display("FAIL full_frame_done: got %0d at cyc %0d want 1 at %0d", done_cnt, done_cyc, last_cyc + 1);
      end
      n_checks++;
      if (busy_bad !== 0) begin
         n_errors++; $display("FAIL full_busy_high: got %0d low cycles want 0", busy_bad);
      end
      n_checks++;
      if (f_busy !== 1'b0 || f_done !== 1'b0) begin
         n_errors++; $display("FAIL full_busy_drop: busy %b done %b want 0 0", f_busy, f_done);
      end
   endtask

   task automatic test_stall_toggle();
      int reads = 0, hs = 0, over = 0, stall_bad = 0, data_bad = 0, done_cnt = 0, extra = 0;
      int last_bad = 0;
      logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
      logic [23:0] pd = '0;
      s_ready = 1'b0;
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      for (int cyc = 0; cyc < 1000 && extra < 8; cyc++) begin
         s_ready = ~s_ready;
         if (pv && !pr && (!s_valid || s_data !== pd || s_last !== pl)) stall_bad++;
         if (s_re) begin
            reads++;
            if (reads - hs / 64 > 2) over++;
         end
         if (s_last !== (s_valid && hs == 127)) last_bad++;
         if (s_valid && s_ready) begin
            if (s_data !== exp_pix(hs)) data_bad++;
            hs++;
         end
         if (s_done) done_cnt++;
         if (done_cnt > 0) extra++;
         pv = s_valid; pr = s_ready; pd = s_data; pl = s_last;
         @(negedge clk);
      end
      n_checks++;
      if (stall_bad !== 0) begin
         n_errors++; $display("FAIL toggle_stall_stable: got %0d unstable cycles want 0", stall_bad);
      end
      n_checks++;
      if (reads !== 2 || over !== 0) begin
         n_errors++; $display("FAIL toggle_reads: got %0d reads %0d overfills want 2 0", reads, over);
      end
      n_checks++;
      if (hs !== 128 || data_bad !== 0) begin
         n_errors++; $display("FAIL toggle_pixels: got %0d (%0d bad) want 128 (0 bad)", hs, data_bad);
      end
      n_checks++;
      if (last_bad !== 0) begin
         n_errors++; $display("FAIL toggle_pix_last: got %0d bad cycles want 0", last_bad);
      end
      n_checks++;
      if (done_cnt !== 1) begin
         n_errors++; $display("FAIL toggle_frame_done: got %0d want 1", done_cnt);
      end
   endtask

   task automatic test_start_ignored();
      int reads = 0, addr_bad = 0, hs = 0, done_cnt = 0, busy_bad = 0;
      s_ready = 1'b1;
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      for (int cyc = 0; cyc < 1000 && done_cnt == 0; cyc++) begin
         s_start = (cyc == 1 || cyc == 40);
         if (s_re) begin
            if (s_addr !== 24'(BASE + reads * 64)) addr_bad++;
            reads++;
         end
         if (!s_busy) busy_bad++;
         if (s_valid) hs++;
         if (s_done) done_cnt++;
         @(negedge clk);
      end
      s_start = 1'b0;
      n_checks++;
      if (reads !== 2 || addr_bad !== 0) begin
         n_errors++; $display("FAIL restart_addr_seq: got %0d reads %0d bad want 2 0", reads, addr_bad);
      end
      n_checks++;
      if (hs !== 128) begin
         n_errors++; $display("FAIL restart_pixels: got %0d want 128", hs);
      end
      n_checks++;
      if (done_cnt !== 1 || busy_bad !== 0) begin
         n_errors++; $display("FAIL restart_busy_done: done %0d busy low %0d want 1 0", done_cnt, busy_bad);
      end
      repeat (3) @(negedge clk);
      n_checks++;
      if (s_busy !== 1'b0) begin
         n_errors++; $display("FAIL restart_idle_after: busy %b want 0", s_busy);
      end
   endtask

   task automatic test_reset_mid();
      int hs = 0, hs2 = 0, done_cnt = 0, done2 = 0;
      int first_addr = -1;
      logic [23:0] first_pix = '1;
      s_ready = 1'b1;
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      for (int cyc = 0; cyc < 400 && hs < 100; cyc++) begin
         if (s_valid) hs++;
         if (s_done) done_cnt++;
         @(negedge clk);
      end
      s_n_rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (hs !== 100 || done_cnt !== 0) begin
         n_errors++; $display("FAIL midrst_progress: got %0d px %0d done want 100 0", hs, done_cnt);
      end
      n_checks++;
      if ({s_busy, s_done, s_re, s_valid, s_last} !== 5'b0 || s_addr !== 24'd0 || s_data !== 24'd0) begin
         n_errors++;
         $display("FAIL midrst_outputs: ctrl %b addr %0d data %h want 00000 0 000000",
                  {s_busy, s_done, s_re, s_valid, s_last}, s_addr, s_data);
      end
      s_n_rst = 1'b1;
      @(negedge clk);
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
      for (int cyc = 0; cyc < 1000 && done2 == 0; cyc++) begin
         if (s_re && first_addr < 0) first_addr = int'(s_addr);
         if (s_valid) begin
            if (hs2 == 0) first_pix = s_data;
            hs2++;
         end
         if (s_done) done2++;
         @(negedge clk);
      end
      n_checks++;
      if (first_addr !== int'(BASE) || first_pix !== 24'h0000A5) begin
         n_errors++;
         $display("FAIL midrst_restart: addr %0d pix %h want %0d 0000a5", first_addr, first_pix, BASE);
      end
      n_checks++;
      if (hs2 !== 128 || done2 !== 1) begin
         n_errors++; $display("FAIL midrst_frame: got %0d px %0d done want 128 1", hs2, done2);
      end
   endtask

`ifdef FRAME_OUT_CRC_EN
   task automatic test_crc();
      int done_cnt = 0;
      logic [15:0] crc_at = '0;
      logic [15:0] want;
      want    = ref_crc_zero(192);
      c_ready = 1'b1;
      c_start = 1'b1;
      @(negedge clk);
      c_start = 1'b0;
      for (int cyc = 0; cyc < 300 && done_cnt == 0; cyc++) begin
         if (c_done) begin
            done_cnt++; crc_at = c_crc;
         end
         @(negedge clk);
      end
      n_checks++;
      if (done_cnt !== 1 || crc_at !== want) begin
         n_errors++; $display("FAIL crc_at_done: got %h (done %0d) want %h", crc_at, done_cnt, want);
      end
      n_checks++;
      if (c_crc !== want) begin
         n_errors++; $display("FAIL crc_stable: got %h want %h", c_crc, want);
      end
   endtask
`endif

   initial begin
      f_start = 1'b0; f_ready = 1'b0; f_n_rst = 1'b0;
      s_start = 1'b0; s_ready = 1'b0; s_n_rst = 1'b0;
`ifdef FRAME_OUT_CRC_EN
      c_start = 1'b0; c_ready = 1'b0; c_n_rst = 1'b0;
`endif
      @(negedge clk);
      test_reset();
      test_ready_low();
      test_full_frame();
      test_stall_toggle();
      test_start_ignored();
      test_reset_mid();
`ifdef FRAME_OUT_CRC_EN
      test_crc();
`endif
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
